// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter in front of an async FIFO write port; grants only when
// the FIFO has room for a full burst plus margin, and tags each word with its source.
module fifo_wr_arbiter #(
    parameter int NUM_REQ          = 4,
    parameter int DATA_WIDTH       = 16,
    parameter int FIFO_DEPTH_WIDTH = 10,
    parameter int BURST_LEN        = 8,
    parameter int MARGIN           = 2,
    localparam int ID_W            = $clog2(NUM_REQ)
) (
    input  logic                          clk_write,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    input  logic [FIFO_DEPTH_WIDTH-1:0]   fifo_count,
    output logic                          fifo_write,
    output logic [ID_W+DATA_WIDTH-1:0]    fifo_data,
    output logic [ID_W-1:0]               grant_id,
    output logic                          busy
);

    localparam int FW   = FIFO_DEPTH_WIDTH;
    localparam int BC_W = $clog2(BURST_LEN);
    localparam logic [FW:0]     DEPTH      = {1'b1, {FW{1'b0}}};
    localparam logic [FW:0]     THRESH     = (FW+1)'(BURST_LEN + MARGIN);
    localparam logic [BC_W-1:0] BEAT_LAST  = BC_W'(BURST_LEN - 1);
    localparam logic [ID_W-1:0] ID_LAST    = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BURST  = 2'd1,
        SETTLE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0] grant_id_q, grant_id_d;
    logic [BC_W-1:0] beat_cnt_q, beat_cnt_d;
    logic            settle_cnt_q, settle_cnt_d;

    logic [FW:0]     space;
    logic            pick_found;
    logic [ID_W-1:0] pick_id;
    logic [ID_W-1:0] next_ptr;

    // A zero count with full low is an empty FIFO, which the subtraction already yields.
    always_comb begin
        space = fifo_full ? '0 : (DEPTH - {1'b0, fifo_count});
    end

    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!pick_found && req_valid[idx]) begin
                pick_found = 1'b1;
                pick_id    = ID_W'(idx);
            end
        end
    end

    assign next_ptr = (grant_id_q == ID_LAST) ? '0 : grant_id_q + ID_W'(1);

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        grant_id_d   = grant_id_q;
        beat_cnt_d   = beat_cnt_q;
        settle_cnt_d = settle_cnt_q;
        req_ready    = '0;
        fifo_write   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found && (space >= THRESH)) begin
                    grant_id_d = pick_id;
                    beat_cnt_d = '0;
                    state_d    = BURST;
                end
            end
            BURST: begin
                req_ready[grant_id_q] = !fifo_full;
                fifo_write            = req_valid[grant_id_q] && !fifo_full;
                if (fifo_write) begin
                    beat_cnt_d = beat_cnt_q + BC_W'(1);
                end
                // A dropped valid ends the burst even while the FIFO is stalling it.
                if (!req_valid[grant_id_q] || (fifo_write && (beat_cnt_q == BEAT_LAST))) begin
                    rr_ptr_d     = next_ptr;
                    settle_cnt_d = 1'b0;
                    state_d      = SETTLE;
                end
            end
            SETTLE: begin
                settle_cnt_d = settle_cnt_q + 1'b1;
                if (settle_cnt_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_write or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            grant_id_q   <= '0;
            beat_cnt_q   <= '0;
            settle_cnt_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_id_q   <= grant_id_d;
            beat_cnt_q   <= beat_cnt_d;
            settle_cnt_q <= settle_cnt_d;
        end
    end

    assign fifo_data = {grant_id_q, req_data[int'(grant_id_q)*DATA_WIDTH +: DATA_WIDTH]};
    assign grant_id  = grant_id_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: per-source payload queues plus a round-robin
// grant model driven from the observed valids and FIFO space.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int FW = 10;
    localparam int BL = 8;
    localparam int MG = 2;
    localparam int IW = 2;

    logic              clk_write = 1'b0;
    logic              rst_n     = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic              fifo_full  = 1'b0;
    logic [FW-1:0]     fifo_count = '0;
    logic              fifo_write;
    logic [IW+DW-1:0]  fifo_data;
    logic [IW-1:0]     grant_id;
    logic              busy;

    always #5 clk_write = ~clk_write;

    fifo_wr_arbiter #(
        .NUM_REQ(N), .DATA_WIDTH(DW), .FIFO_DEPTH_WIDTH(FW), .BURST_LEN(BL), .MARGIN(MG)
    ) dut (
        .clk_write (clk_write),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .fifo_full (fifo_full),
        .fifo_count(fifo_count),
        .fifo_write(fifo_write),
        .fifo_data (fifo_data),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    // Producers: requester i presents (i<<7)+seq[i] and advances seq on every accepted beat.
    int seq[N];
    logic [DW-1:0] exp_q[N][$];

    function automatic logic [DW-1:0] word(input int i, input int s);
        return DW'((i << 7) + s);
    endfunction

    always_comb begin
        req_data = '0;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = word(i, seq[i]);
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int winner(input logic [N-1:0] v, input int rr);
        for (int k = 0; k < N; k++) begin
            if (v[(rr + k) % N]) return (rr + k) % N;
        end
        return -1;
    endfunction

    // Monitor / reference model state
    logic [N-1:0] hs_m       = '0;
    logic [N-1:0] valid_prev = '0;
    logic         busy_prev  = 1'b0;
    int rr_m = 0, space_prev = 0, cur_beats = 0, last_burst_len = -1, cyc = 0;
    int grants[$];
    int burst_lens[$];
    int wr_cycles[$];

    initial begin
        forever begin
            @(negedge clk_write);
            cyc++;
            if (!rst_n) begin
                rr_m = 0; busy_prev = 1'b0; valid_prev = '0; space_prev = 0;
                cur_beats = 0; hs_m = '0;
                chk("reset_write", int'(fifo_write), 0);
                chk("reset_busy", int'(busy), 0);
                chk("reset_ready", int'(req_ready), 0);
            end else begin
                hs_m = req_valid & req_ready;
                chk("ready_onehot", int'($countones(req_ready) <= 1), 1);
                if (!busy_prev) begin
                    if (valid_prev != '0 && space_prev >= BL + MG) begin
                        int w;
                        w = winner(valid_prev, rr_m);
                        chk("grant_busy", int'(busy), 1);
                        chk("grant_id", int'(grant_id), w);
                        grants.push_back(w);
                        rr_m = (w + 1) % N;
                        cur_beats = 0;
                    end else begin
                        chk("idle_hold", int'(busy), 0);
                    end
                end else if (!busy) begin
                    last_burst_len = cur_beats;
                    burst_lens.push_back(cur_beats);
                    chk("burst_len_max", int'(cur_beats <= BL), 1);
                end
                chk("write_vs_handshake", int'(fifo_write), int'(|hs_m));
                if (fifo_write) begin
                    int id;
                    id = int'(fifo_data[DW +: IW]);
                    chk("write_while_busy", int'(busy), 1);
                    chk("write_tag_source", int'(hs_m[id]), 1);
                    if (exp_q[id].size() == 0) begin
                        chk("write_unexpected", 1, 0);
                    end else begin
                        chk("write_payload", int'(fifo_data[DW-1:0]), int'(exp_q[id][0]));
                        void'(exp_q[id].pop_front());
                    end
                    wr_cycles.push_back(cyc);
                    cur_beats++;
                end
                busy_prev  = busy;
                valid_prev = req_valid;
                space_prev = fifo_full ? 0 : (1 << FW) - int'(fifo_count);
            end
        end
    end

    task automatic cycle();
        @(posedge clk_write);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs_m[i]) begin
                seq[i]++;
                exp_q[i].push_back(word(i, seq[i]));
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic wait_busy(input logic val, input string name);
        int n;
        n = 0;
        while (busy !== val && n < 200) begin
            cycle();
            n++;
        end
        chk(name, int'(busy), int'(val));
    endtask

    task automatic wait_idle(input string name);
        req_valid = '0;
        wait_busy(1'b0, name);
        cycle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, s0;
        for (int i = 0; i < N; i++) begin
            seq[i] = 0;
            exp_q[i].push_back(word(i, 0));
        end

        // Reset values
        cycle();
        chk("rst_busy", int'(busy), 0);
        chk("rst_write", int'(fifo_write), 0);
        chk("rst_ready", int'(req_ready), 0);
        chk("rst_grant_id", int'(grant_id), 0);
        cycle();
        rst_n = 1'b1;
        cycle();
        chk("post_rst_idle", int'(busy), 0);

        // 1: requester 2 alone -> 8 consecutive writes, 3-cycle gap
        wr_cycles.delete();
        req_valid = 4'b0100;
        n = 0;
        while (wr_cycles.size() < 24 && n < 100) begin cycle(); n++; end
        req_valid = '0;
        chk("t1_writes", wr_cycles.size(), 24);
        for (int k = 1; k < wr_cycles.size(); k++)
            chk("t1_spacing", wr_cycles[k] - wr_cycles[k-1], (k % 8 == 0) ? 4 : 1);
        wait_idle("t1_idle");

        // 2: all requesters valid -> 0,1,2,3,0 with full bursts
        do_reset();
        grants.delete(); burst_lens.delete();
        req_valid = '1;
        n = 0;
        while (grants.size() < 5 && n < 200) begin cycle(); n++; end
        wait_idle("t2_idle");
        chk("t2_grants", grants.size(), 5);
        for (int k = 0; k < grants.size() && k < 5; k++) chk("t2_order", grants[k], k % N);
        chk("t2_bursts", int'(burst_lens.size() >= 4), 1);
        for (int k = 0; k < burst_lens.size() && k < 4; k++) chk("t2_burst_len", burst_lens[k], BL);

        // 3: requester 1 drops after 3 beats -> next grant to 2
        grants.delete(); burst_lens.delete();
        s0 = seq[1];
        req_valid = 4'b0010;
        n = 0;
        while (grants.size() < 1 && n < 50) begin cycle(); n++; end
        req_valid = 4'b1111;
        n = 0;
        while (seq[1] < s0 + 3 && n < 50) begin cycle(); n++; end
        req_valid[1] = 1'b0;
        n = 0;
        while (grants.size() < 2 && n < 50) begin cycle(); n++; end
        wait_idle("t3_idle");
        chk("t3_grants", int'(grants.size() >= 2), 1);
        if (grants.size() >= 2) begin
            chk("t3_first", grants[0], 1);
            chk("t3_next", grants[1], 2);
        end
        chk("t3_bursts", int'(burst_lens.size() >= 1), 1);
        if (burst_lens.size() >= 1) chk("t3_short_burst", burst_lens[0], 3);

        // 4: space 9 blocks, space 10 grants
        req_valid  = 4'b0001;
        fifo_count = FW'(1015);
        for (int k = 0; k < 6; k++) begin cycle(); chk("t4_no_grant", int'(busy), 0); end
        s0 = seq[0];
        fifo_count = FW'(1014);
        cycle();
        chk("t4_grant", int'(busy), 1);
        fifo_count = '0;

        // 5: full stall of 4 cycles mid-burst, burst still 8 beats
        n = 0;
        while (seq[0] < s0 + 3 && n < 50) begin cycle(); n++; end
        fifo_full = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t5_stall_write", int'(fifo_write), 0);
            chk("t5_stall_ready", int'(req_ready), 0);
            cycle();
        end
        fifo_full = 1'b0;
        n = 0;
        while (seq[0] < s0 + BL && n < 50) begin cycle(); n++; end
        wait_idle("t5_idle");
        chk("t5_burst_len", last_burst_len, BL);

        // 6: reset during beat 5, then first grant goes to requester 0
        req_valid = 4'b0010;
        s0 = seq[1];
        n = 0;
        while (seq[1] < s0 + 4 && n < 50) begin cycle(); n++; end
        #1;
        chk("t6_beat5_live", int'(fifo_write), 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_write", int'(fifo_write), 0);
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_ready", int'(req_ready), 0);
        chk("t6_rst_grant_id", int'(grant_id), 0);
        req_valid = '1;
        cycle();
        cycle();
        grants.delete();
        rst_n = 1'b1;
        n = 0;
        while (grants.size() < 1 && n < 50) begin cycle(); n++; end
        chk("t6_first_grant", (grants.size() > 0) ? grants[0] : -1, 0);
        wait_idle("t6_idle");

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (req_valid[i]) begin
                    if ($urandom_range(0, 9) == 0) req_valid[i] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    req_valid[i] = 1'b1;
                end
            end
            fifo_full  = ($urandom_range(0, 29) == 0);
            fifo_count = ($urandom_range(0, 9) == 0) ? FW'($urandom_range(1008, 1023))
                                                     : FW'($urandom_range(0, 1000));
            cycle();
        end
        fifo_full  = 1'b0;
        fifo_count = '0;
        wait_idle("rand_idle");
        for (int i = 0; i < N; i++) chk("drain_queue", exp_q[i].size(), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Write-side burst arbiter that shares a single asynchronous FIFO write port among `NUM_REQ` producers in the `clk_write` domain, such as the camera line packer, the upscaler output and the debug injector. It grants one requester at a time for a bounded burst, and only when the FIFO's write-domain occupancy shows room for the whole burst. Each word is tagged with the source index so the read-domain consumer can demultiplex it. The block sits directly in front of the async FIFO's `write`/`data_write`/`full`/`data_count_w` ports.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `DATA_WIDTH`, default 16: payload width per requester.
- `FIFO_DEPTH_WIDTH`, default 10: FIFO depth is 2**`FIFO_DEPTH_WIDTH`. Must match the FIFO instance.
- `BURST_LEN`, default 8: maximum beats per grant, at least 2.
- `MARGIN`, default 2: extra free words required beyond `BURST_LEN` before a grant is issued.
- `ID_W`: localparam, clog2(`NUM_REQ`).

Ports:
- `clk_write` in 1: write-domain clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in `NUM_REQ`: per-requester data valid.
- `req_data` in `NUM_REQ`*`DATA_WIDTH`: flattened payloads. Requester i occupies bits [i*`DATA_WIDTH` +: `DATA_WIDTH`].
- `req_ready` out `NUM_REQ`: per-requester accept. A beat transfers when `req_valid[i]` and `req_ready[i]` are both high.
- `fifo_full` in 1: FIFO `full` flag.
- `fifo_count` in `FIFO_DEPTH_WIDTH`: FIFO `data_count_w`.
- `fifo_write` out 1: FIFO write strobe.
- `fifo_data` out `ID_W`+`DATA_WIDTH`: {grant id, payload}.
- `grant_id` out `ID_W`: current or last granted index.
- `busy` out 1: high in BURST and SETTLE.

## Operation
- The FSM has three states: IDLE, BURST and SETTLE. Reset enters IDLE.
- Free space is computed as follows:
  - `space` = 2**`FIFO_DEPTH_WIDTH` − `fifo_count`, evaluated `FIFO_DEPTH_WIDTH`+1 bits wide.
  - If `fifo_full` is high, `space` is forced to 0.
  - `fifo_count` = 0 with `fifo_full` low means the FIFO is empty and `space` = full depth.
- IDLE:
  - A grant is issued only if some `req_valid` is high and `space` ≥ `BURST_LEN`+`MARGIN`.
  - The winner is chosen round-robin: the first valid index at or after `rr_ptr`, scanning upward and wrapping modulo `NUM_REQ`.
  - On grant, `grant_id` is registered, `beat_cnt` is cleared to 0, and the FSM moves to BURST.
  - Otherwise it stays in IDLE.
- BURST:
  - `req_ready[grant_id]` = !`fifo_full`. Every other ready is 0.
  - `fifo_write` = `req_valid[grant_id]` && !`fifo_full`, combinational.
  - `fifo_data` = {`grant_id`, `req_data` slice of `grant_id`}, combinational.
  - Each accepted beat increments `beat_cnt`.
  - The burst ends when a beat is accepted with `beat_cnt` == `BURST_LEN`−1.
  - The burst also ends early on any cycle where `req_valid[grant_id]` is 0, whether or not `fifo_full` is high.
  - If `fifo_full` is high while valid stays high, the state holds and the burst does not end. This is a backstop only; the space check should prevent it.
  - At burst end, `rr_ptr` ← (`grant_id`+1) mod `NUM_REQ` and the FSM moves to SETTLE.
- SETTLE:
  - Lasts exactly 2 cycles, counted by the settle counter.
  - Outputs are idle: all readies 0 and `fifo_write` 0.
  - This lets `data_count_w`, which lags `w_ptr` by one registered stage, reflect the last beat before the next space check.
  - After 2 cycles the FSM returns to IDLE.
- `grant_id` holds its value outside BURST. `fifo_data` outside BURST is don't-care, but `fifo_write` must be 0.
- No requester waits more than (`NUM_REQ`−1) bursts once valid. This holds whenever `space` recovers.

## Timing
- Reset values: state IDLE, `rr_ptr` 0, `grant_id` 0, `beat_cnt` 0, `busy` 0, `req_ready` all 0, `fifo_write` 0.
- Grant latency: valid is sampled in IDLE at edge t, so BURST is active and ready is high in cycle t+1. The first beat can land at edge t+1.
- A full-length back-to-back burst from one requester is `BURST_LEN` cycles, then 2 SETTLE cycles, then at least 1 IDLE cycle.
- Minimum re-grant period is therefore `BURST_LEN`+3 cycles.
- `req_valid` and `fifo_full` are combinationally reflected in `fifo_write` within the BURST cycle. There is no registered output stage.
- Deasserting `rst_n` mid-burst aborts the burst immediately: `fifo_write` drops asynchronously, and partial beats already written remain in the FIFO.
- Simultaneous valids in IDLE are resolved by `rr_ptr` only. No fixed priority applies.

## Test plan
- Single requester, `NUM_REQ`=4, requester 2 continuously valid with data 0x0100 + n, empty FIFO -> bursts of 8 with `fifo_write` on 8 consecutive cycles and a 3-cycle gap, `fifo_data` = {2, 0x0100+n}, data in order with none lost.
- All 4 requesters continuously valid -> grant order 0,1,2,3,0,..., each burst exactly 8 beats, `rr_ptr` advancing after each.
- Requester 1 drops valid after 3 beats -> burst ends early, SETTLE follows, `rr_ptr`=2, and the next grant goes to 2 if valid.
- `fifo_count`=1015 with depth 1024 (`space`=9 < 10) -> no grant and `busy` stays 0. Moving `fifo_count` to 1014 -> grant on the next cycle.
- Force `fifo_full` high for 4 cycles mid-burst with valid held -> `fifo_write` 0 and ready 0 during those cycles, the burst resumes, and 8 beats total are written.
- Assert `rst_n` low during beat 5 -> all outputs reach reset values asynchronously. After release, the first grant goes to requester 0 with `rr_ptr`=0.
